keypad_decoder: RTL
===================

# keypad_decoder

Scans a 4x4 matrix keypad (Pmod KYPD), debounces it and presents one decoded key to the game logic. It sits directly upstream of the game block and drives that block's `dec` and `button_pressed` inputs. The game block edge-detects `button_pressed` itself; this block supplies a clean level plus a one-cycle `key_valid` strobe for other consumers.

## Interface
- `SCAN_CYCLES`, 100000: clock cycles each column is driven (dwell); must be ≥ 4.
- `DEBOUNCE_SCANS`, 4: consecutive full scans needed to accept a press or a release; must be ≥ 1.

- `clk` input 1: master clock.
- `rst` input 1: reset, synchronous and active-high.
- `row` input 4: keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col` output 4: column drive, active-low, exactly one bit low at any time.
- `dec` output 4: code of the last accepted key; held after release.
- `button_pressed` output 1: high while the accepted key is held (debounced level).
- `key_valid` output 1: one-cycle pulse on each accepted press.

## Operation
- Key map, as `col` index c (0..3) / `row` index r (0..3):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
  - Codes are the hex value, so A=4'hA (start) and B=4'hB (reset to select).
- `row` passes through a 2-flop synchronizer before any use.
- Scan: dwell counter (width $clog2(SCAN_CYCLES)) counts 0..SCAN_CYCLES-1 per column.
  - At count SCAN_CYCLES-1, synced `row` is sampled for the active column.
  - On the next edge `col` advances c0→c1→c2→c3→c0.
  - A "scan" is complete at the col3 sample.
- Scan candidate: the first pressed key in order c0r0, c0r1 … c3r3. Lowest index wins on multiple presses; otherwise "none".
- Debounce FSM, evaluated once per scan at the col3 sample, counter width $clog2(DEBOUNCE_SCANS+1):
  - IDLE:
    - Candidate X → CONFIRM_PRESS, cnt=1, cand=X.
    - If DEBOUNCE_SCANS=1, accept immediately instead.
  - CONFIRM_PRESS:
    - Same X → cnt+1. On reaching DEBOUNCE_SCANS, accept: → PRESSED, `dec`←code(X), `button_pressed`←1, `key_valid` pulses.
    - Different key Y → cand=Y, cnt=1.
    - None → IDLE.
  - PRESSED:
    - None → CONFIRM_RELEASE, cnt=1.
    - If DEBOUNCE_SCANS=1, release immediately.
    - Any key (same or other) → stay.
  - CONFIRM_RELEASE:
    - None → cnt+1. On reaching DEBOUNCE_SCANS → IDLE, `button_pressed`←0.
    - Any key → PRESSED, cnt=0.
- A second key pressed while one is accepted never produces a new press. The user must release fully first.
- `dec` changes only on acceptance; it never changes on release.

## Timing
- Reset values:
  - `col`=4'b1110.
  - `dec`=4'h0, `button_pressed`=0, `key_valid`=0.
  - FSM=IDLE, all counters 0, synchronizer flops=4'b1111.
- Reset mid-operation returns every register to these values on the same edge. A key held across reset needs a full DEBOUNCE_SCANS new scans before acceptance.
- One scan = 4×SCAN_CYCLES cycles. Outputs are registered and change on the edge that evaluates the col3 sample.
- `row` path latency: 2 synchronizer cycles. Only the final sample of each dwell is used, so the row must be stable for the last 3 cycles of the dwell.
- Press latency: a key stable from the start of a scan is accepted at the end of scan DEBOUNCE_SCANS, i.e. ≤ (DEBOUNCE_SCANS+1)×4×SCAN_CYCLES cycles.
- Release latency is the same bound.
- `key_valid` is high exactly one cycle, coincident with the first cycle `button_pressed`=1.
- Counters never wrap beyond their terminal values. The dwell counter wraps SCAN_CYCLES-1→0 as it advances `col`.

## Test plan
Use SCAN_CYCLES=4, DEBOUNCE_SCANS=3 (one scan = 16 cycles).
- **Reset:** assert `rst` 2 cycles with `row`=4'b1111 → `col`=1110, `dec`=0, `button_pressed`=0. `col` then rotates 1101, 1011, 0111 every 4 cycles.
- **Clean press of A:** hold row0 low only while `col`=0111 for 4 scans → `dec`=4'hA, `button_pressed`=1 and a single `key_valid` pulse at the end of scan 3. Release → `button_pressed`=0 after 3 empty scans; `dec` stays 4'hA.
- **Bounce:** key 5 (c1r1) present in scans 1 and 2, absent in scan 3, present in scans 4-6 → no accept until end of scan 6, then `dec`=4'h5.
- **Two keys:** 1 (c0r0) and D (c3r3) held together → `dec`=4'h1. Then release 1 while keeping D → `button_pressed` stays 1, no new `key_valid`, `dec`=4'h1.
- **Reset mid-confirm:** B (c3r1) held 2 scans, `rst` pulsed, B held on → acceptance requires 3 further scans after reset; `dec`=4'hB.
- **Short glitch on release:** after acceptance of 0, give 2 empty scans then 1 scan with 0 → `button_pressed` never drops and no `key_valid` pulse.

Source files
------------

// File: rtl/keypad_decoder_if.sv
// keypad_decoder_if: signal bundle between the keypad matrix, the decoder and its consumers.
// Latency: none (wires only).
// Backpressure: none; consumers sample dec/button_pressed as levels and key_valid as a strobe.
// Signals: row (keypad rows, active-low), col (column drive, active-low one-cold),
//          dec (last accepted key code), button_pressed (debounced level), key_valid (press strobe).
// master = decoder side, slave = keypad/consumer side.
interface keypad_decoder_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] dec;
  logic       button_pressed;
  logic       key_valid;

  modport master (
    input  row,
    output col,
    output dec,
    output button_pressed,
    output key_valid
  );

  modport slave (
    output row,
    input  col,
    input  dec,
    input  button_pressed,
    input  key_valid
  );
endinterface

// File: rtl/keypad_decoder.sv
// keypad_decoder: scans a 4x4 active-low keypad, debounces over whole scans, reports one key.
// Latency: press/release accepted at the end of scan DEBOUNCE_SCANS (<= (DEBOUNCE_SCANS+1)*4*SCAN_CYCLES cycles).
// Backpressure: none; outputs are registered levels plus a one-cycle key_valid strobe.
// Ports: clk, rst (sync, active-high); kp.master carries row in, col/dec/button_pressed/key_valid out.
module keypad_decoder #(
  parameter int SCAN_CYCLES    = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_decoder_if.master  kp
);

  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_TARGET = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM_PRESS,
    PRESSED,
    CONFIRM_RELEASE
  } state_t;

  // Row synchronizer; idle (all released) value out of reset.
  logic [3:0]    row_meta_q, row_sync_q;

  // Scan datapath.
  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    col_q, col_d;
  logic [11:0]   seen_q, seen_d;   // pressed bits of columns 0..2 for the current scan

  // Debounce FSM.
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    cand_q;
  logic [3:0]    dec_q;
  logic          pressed_q;
  logic          valid_q;

  logic          dwell_end, scan_end;
  logic [15:0]   scan_vec;
  logic          cand_vld;
  logic [3:0]    cand_idx;
  logic [CW-1:0] cnt_inc;

  function automatic logic [3:0] key_code(input logic [3:0] idx);
    // idx = col*4 + row
    case (idx)
      4'd0:    key_code = 4'h1;
      4'd1:    key_code = 4'h4;
      4'd2:    key_code = 4'h7;
      4'd3:    key_code = 4'h0;
      4'd4:    key_code = 4'h2;
      4'd5:    key_code = 4'h5;
      4'd6:    key_code = 4'h8;
      4'd7:    key_code = 4'hF;
      4'd8:    key_code = 4'h3;
      4'd9:    key_code = 4'h6;
      4'd10:   key_code = 4'h9;
      4'd11:   key_code = 4'hE;
      4'd12:   key_code = 4'hA;
      4'd13:   key_code = 4'hB;
      4'd14:   key_code = 4'hC;
      default: key_code = 4'hD;
    endcase
  endfunction

  assign dwell_end = (dwell_q == DWELL_LAST);
  assign scan_end  = dwell_end && (col_q == 4'b0111);
  // Column 3 is not stored; it is taken live at its own sample point.
  assign scan_vec  = {~row_sync_q, seen_q};
  assign cnt_inc   = cnt_q + CW'(1);

  // Lowest index wins: scanning downward lets the last hit overwrite.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (scan_vec[i]) begin
        cand_vld = 1'b1;
        cand_idx = 4'(i);
      end
    end
  end

  always_comb begin
    dwell_d = dwell_q + DW'(1);
    col_d   = col_q;
    seen_d  = seen_q;
    if (dwell_end) begin
      dwell_d = '0;
      col_d   = {col_q[2:0], col_q[3]};
      case (col_q)
        4'b1110: seen_d[3:0]  = ~row_sync_q;
        4'b1101: seen_d[7:4]  = ~row_sync_q;
        4'b1011: seen_d[11:8] = ~row_sync_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
      dwell_q    <= '0;
      col_q      <= 4'b1110;
      seen_q     <= '0;
    end else begin
      row_meta_q <= kp.row;
      row_sync_q <= row_meta_q;
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      seen_q     <= seen_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cand_q    <= 4'd0;
      dec_q     <= 4'h0;
      pressed_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (scan_end) begin
        case (state_q)
          IDLE: begin
            if (cand_vld) begin
              if (DEBOUNCE_SCANS == 1) begin
                state_q   <= PRESSED;
                cnt_q     <= '0;
                dec_q     <= key_code(cand_idx);
                pressed_q <= 1'b1;
                valid_q   <= 1'b1;
              end else begin
                state_q <= CONFIRM_PRESS;
                cnt_q   <= CW'(1);
                cand_q  <= cand_idx;
              end
            end
          end
          CONFIRM_PRESS: begin
            if (!cand_vld) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cand_idx != cand_q) begin
              // A different key restarts confirmation on the new key.
              cand_q <= cand_idx;
              cnt_q  <= CW'(1);
            end else if (cnt_inc == DEB_TARGET) begin
              state_q   <= PRESSED;
              cnt_q     <= '0;
              dec_q     <= key_code(cand_q);
              pressed_q <= 1'b1;
              valid_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          PRESSED: begin
            // Any key keeps the press alive; no re-trigger until a full release.
            if (!cand_vld) begin
              if (DEBOUNCE_SCANS == 1) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                pressed_q <= 1'b0;
              end else begin
                state_q <= CONFIRM_RELEASE;
                cnt_q   <= CW'(1);
              end
            end
          end
          default: begin // CONFIRM_RELEASE
            if (cand_vld) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end else if (cnt_inc == DEB_TARGET) begin
              state_q   <= IDLE;
              cnt_q     <= '0;
              pressed_q <= 1'b0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        endcase
      end
    end
  end

  assign kp.col            = col_q;
  assign kp.dec            = dec_q;
  assign kp.button_pressed = pressed_q;
  assign kp.key_valid      = valid_q;

endmodule
